// File: rtl/im_loader.sv
// Instruction-memory loader: turns a length-prefixed byte stream into big-endian
// 32-bit words written to the instruction store, holding the CPU until a load succeeds.
module im_loader #(
    parameter int ADDR_W = 12,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold,
    output logic [12:0]       word_count
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t state_q, state_d;

    logic [7:0]        lenHi_q;
    logic [12:0]       len_q;
    logic [1:0]        byteCnt_q;
    logic [23:0]       shift_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [12:0]       wordCount_q;

    logic              inReady_q;
    logic              imWe_q;
    logic [ADDR_W-1:0] imAddr_q;
    logic [31:0]       imWdata_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic              cpuHold_q;

    logic        accept;
    logic [15:0] lenIn;
    logic        lenBad;
    logic        lastWord;

    assign accept   = in_valid && inReady_q;
    assign lenIn    = {lenHi_q, in_data};
    assign lenBad   = (lenIn == 16'd0) || (lenIn > 16'd4096);
    assign lastWord = (wordCount_q + 13'd1) == len_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE, ERR: if (start) state_d = LEN_HI;
            LEN_HI:          if (accept) state_d = LEN_LO;
            LEN_LO:          if (accept) state_d = lenBad ? ERR : DATA;
            DATA:            if (accept && byteCnt_q == 2'd3) state_d = WRITE;
            WRITE:           state_d = lastWord ? DONE : DATA;
            default:         state_d = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lenHi_q     <= '0;
            len_q       <= '0;
            byteCnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            wordCount_q <= '0;
            inReady_q   <= 1'b0;
            imWe_q      <= 1'b0;
            imAddr_q    <= '0;
            imWdata_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpuHold_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            inReady_q <= (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == DATA);
            busy_q    <= (state_d == LEN_HI) || (state_d == LEN_LO) ||
                         (state_d == DATA)   || (state_d == WRITE);
            imWe_q    <= (state_d == WRITE);
            done_q    <= (state_d == DONE);
            error_q   <= (state_d == ERR);
            cpuHold_q <= (state_d != DONE);

            unique case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        ptr_q       <= ADDR_W'(BASE);
                        wordCount_q <= '0;
                        byteCnt_q   <= '0;
                    end
                end
                LEN_HI: begin
                    if (accept) lenHi_q <= in_data;
                end
                LEN_LO: begin
                    if (accept) len_q <= lenIn[12:0];
                end
                DATA: begin
                    if (accept) begin
                        shift_q   <= {shift_q[15:0], in_data};
                        byteCnt_q <= byteCnt_q + 2'd1;
                        if (byteCnt_q == 2'd3) begin
                            imAddr_q  <= ptr_q;
                            imWdata_q <= {shift_q, in_data};
                        end
                    end
                end
                WRITE: begin
                    ptr_q       <= ptr_q + 1'b1;
                    wordCount_q <= wordCount_q + 13'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = inReady_q;
    assign im_we      = imWe_q;
    assign im_addr    = imAddr_q;
    assign im_wdata   = imWdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_hold   = cpuHold_q;
    assign word_count = wordCount_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: two-word program loads, bad lengths, address wrap,
// mid-load reset and ignored start pulses.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        in_ready, im_we, busy, done, error, cpu_hold;
    logic [11:0] im_addr;
    logic [31:0] im_wdata;
    logic [12:0] word_count;

    logic        in_ready1, im_we1, busy1, done1, error1, cpu_hold1;
    logic [11:0] im_addr1;
    logic [31:0] im_wdata1;
    logic [12:0] word_count1;

    int checks = 0;
    int passes = 0;
    int acceptCount = 0;
    int overlapCount = 0;

    logic [11:0] addrQ[$];
    logic [31:0] dataQ[$];
    logic [11:0] addrQ1[$];
    logic [31:0] dataQ1[$];
    logic [7:0]  progBytes[10];

    im_loader #(.ADDR_W(12), .BASE(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold), .word_count(word_count)
    );

    im_loader #(.ADDR_W(12), .BASE(4095)) dutWrap (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .im_we(im_we1), .im_addr(im_addr1), .im_wdata(im_wdata1),
        .busy(busy1), .done(done1), .error(error1), .cpu_hold(cpu_hold1), .word_count(word_count1)
    );

    always #5 clk = ~clk;

    // Record every write and every accepted byte, seen with pre-edge values.
    always @(posedge clk) begin
        if (in_valid && in_ready) acceptCount++;
        if (im_we && in_ready) overlapCount++;
        if (im_we) begin
            addrQ.push_back(im_addr);
            dataQ.push_back(im_wdata);
        end
        if (im_we1) begin
            addrQ1.push_back(im_addr1);
            dataQ1.push_back(im_wdata1);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte and return at the negedge after it was accepted.
    task automatic sendByte(input logic [7:0] b, input bit gap);
        int n = 0;
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rdyWait", 32'(n < 20), 32'd1);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit gap);
        pulseStart();
        checkOutput("startRdy", 32'(in_ready), 32'd1);
        checkOutput("startBusy", 32'(busy), 32'd1);
        for (int i = 0; i < 10; i++) begin
            sendByte(progBytes[i], gap);
            if (i == 5) begin
                checkOutput("weWord0", 32'(im_we), 32'd1);
                checkOutput("wcBefore", 32'(word_count), 32'd0);
            end
        end
        in_valid = 1'b0;
        checkOutput("weLast", 32'(im_we), 32'd1);
        checkOutput("doneEarly", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("doneOn", 32'(done), 32'd1);
        checkOutput("holdOff", 32'(cpu_hold), 32'd0);
        checkOutput("wcFinal", 32'(word_count), 32'd2);
        checkOutput("rdyDone", 32'(in_ready), 32'd0);
        checkOutput("busyDone", 32'(busy), 32'd0);
        checkOutput("weOff", 32'(im_we), 32'd0);
    endtask

    task automatic checkWrites(input int wrBase, input int accBase, input int ovlBase);
        checkOutput("nWrites", 32'(addrQ.size() - wrBase), 32'd2);
        if (addrQ.size() >= wrBase + 2) begin
            checkOutput("addr0", 32'(addrQ[wrBase]), 32'h000);
            checkOutput("data0", dataQ[wrBase], 32'h2408_0005);
            checkOutput("addr1", 32'(addrQ[wrBase + 1]), 32'h001);
            checkOutput("data1", dataQ[wrBase + 1], 32'h0000_000C);
        end
        checkOutput("nAccepts", 32'(acceptCount - accBase), 32'd10);
        checkOutput("acceptInWrite", 32'(overlapCount - ovlBase), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "Rdy"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "We"}, 32'(im_we), 32'd0);
        checkOutput({tag, "Addr"}, 32'(im_addr), 32'd0);
        checkOutput({tag, "Wdata"}, im_wdata, 32'd0);
        checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "Done"}, 32'(done), 32'd0);
        checkOutput({tag, "Err"}, 32'(error), 32'd0);
        checkOutput({tag, "Hold"}, 32'(cpu_hold), 32'd1);
        checkOutput({tag, "Wc"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        int wrBase, wrBase1, accBase, ovlBase;
        progBytes = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkResetValues("rst");
        reset_n = 1'b1;
        @(negedge clk);
        checkResetValues("idle");

        $display("[TB] load with in_valid held high");
        wrBase = addrQ.size(); wrBase1 = addrQ1.size();
        accBase = acceptCount; ovlBase = overlapCount;
        applyStimulus(1'b0);
        checkWrites(wrBase, accBase, ovlBase);
        checkOutput("wrapN", 32'(addrQ1.size() - wrBase1), 32'd2);
        if (addrQ1.size() >= wrBase1 + 2) begin
            checkOutput("wrapAddr0", 32'(addrQ1[wrBase1]), 32'hFFF);
            checkOutput("wrapAddr1", 32'(addrQ1[wrBase1 + 1]), 32'h000);
            checkOutput("wrapData1", dataQ1[wrBase1 + 1], 32'h0000_000C);
        end
        checkOutput("wrapDone", 32'(done1), 32'd1);
        checkOutput("wrapHold", 32'(cpu_hold1), 32'd0);
        checkOutput("wrapErr", 32'(error1), 32'd0);
        checkOutput("wrapWc", 32'(word_count1), 32'd2);
        checkOutput("wrapIdle", {30'd0, in_ready1, busy1}, 32'd0);

        $display("[TB] load with in_valid toggling");
        wrBase = addrQ.size(); accBase = acceptCount; ovlBase = overlapCount;
        applyStimulus(1'b1);
        checkWrites(wrBase, accBase, ovlBase);

        $display("[TB] zero and oversize lengths");
        wrBase = addrQ.size();
        pulseStart();
        sendByte(8'h00, 1'b0);
        sendByte(8'h00, 1'b0);
        in_valid = 1'b0;
        checkOutput("zeroErr", 32'(error), 32'd1);
        checkOutput("zeroHold", 32'(cpu_hold), 32'd1);
        checkOutput("zeroBusy", 32'(busy), 32'd0);
        checkOutput("zeroRdy", 32'(in_ready), 32'd0);
        checkOutput("zeroWc", 32'(word_count), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("zeroSticky", 32'(error), 32'd1);
        pulseStart();
        checkOutput("errClear", 32'(error), 32'd0);
        sendByte(8'h10, 1'b0);
        sendByte(8'h01, 1'b0);
        in_valid = 1'b0;
        checkOutput("bigErr", 32'(error), 32'd1);
        checkOutput("bigHold", 32'(cpu_hold), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("badNoWrites", 32'(addrQ.size() - wrBase), 32'd0);
        wrBase = addrQ.size(); accBase = acceptCount; ovlBase = overlapCount;
        applyStimulus(1'b0);
        checkWrites(wrBase, accBase, ovlBase);
        checkOutput("errAfterGood", 32'(error), 32'd0);

        $display("[TB] reset in the middle of a load");
        wrBase = addrQ.size();
        pulseStart();
        for (int i = 0; i < 7; i++) sendByte(progBytes[i], 1'b0);
        in_valid = 1'b0;
        checkOutput("partialWr", 32'(addrQ.size() - wrBase), 32'd1);
        reset_n = 1'b0;
        #1;
        checkResetValues("midRst");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("noWrAfterRst", 32'(addrQ.size() - wrBase), 32'd1);
        checkOutput("rstHold", 32'(cpu_hold), 32'd1);
        checkOutput("rstRdy", 32'(in_ready), 32'd0);
        wrBase = addrQ.size(); accBase = acceptCount; ovlBase = overlapCount;
        applyStimulus(1'b0);
        checkWrites(wrBase, accBase, ovlBase);

        $display("[TB] start pulse during DATA");
        wrBase = addrQ.size(); accBase = acceptCount; ovlBase = overlapCount;
        pulseStart();
        for (int i = 0; i < 4; i++) sendByte(progBytes[i], 1'b0);
        in_valid = 1'b0;
        pulseStart();
        checkOutput("midStartBusy", 32'(busy), 32'd1);
        checkOutput("midStartRdy", 32'(in_ready), 32'd1);
        for (int i = 4; i < 10; i++) sendByte(progBytes[i], 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("midStartDone", 32'(done), 32'd1);
        checkOutput("midStartWc", 32'(word_count), 32'd2);
        checkWrites(wrBase, accBase, ovlBase);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/im_loader.md
# im_loader

Writer side of the instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written into the 4096-word instruction store through a word-addressed write port. The CPU is held off until a complete program is loaded, so programs can be loaded at run time instead of from a fixed memory image.

## Interface
Parameters:
- `ADDR_W`, default 12: word-address width; matches the `[13:2]` instruction word index (4096 words).
- `BASE`, default 0: word index of the first loaded instruction.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a load.
- `in_valid` in 1: source has a byte on `in_data`.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader can accept a byte this cycle.
- `im_we` out 1: write strobe to the instruction store, one cycle per word.
- `im_addr` out 12: word index `[13:2]` of the write.
- `im_wdata` out 32: instruction word.
- `busy` out 1: load in progress.
- `done` out 1: last load completed successfully.
- `error` out 1: last load rejected because of a bad length.
- `cpu_hold` out 1: keeps the CPU from fetching.
- `word_count` out 13: words written in the current or last load.

## Operation
- A byte is accepted on a rising edge where `in_valid && in_ready`. `in_data` is ignored otherwise.
- Stream format: 2-byte length N (big-endian, high byte first), then 4N bytes. Each word is big-endian: the first byte goes to bits 31:24, the fourth to bits 7:0.
- States:
  - IDLE: reset state; waits for `start`.
  - LEN_HI: accepts the length high byte.
  - LEN_LO: accepts the length low byte.
  - DATA: accepts word bytes.
  - WRITE: issues the memory write.
  - DONE: load complete.
  - ERR: load rejected.
- Transitions:
  - IDLE/DONE/ERR + `start` -> LEN_HI. This clears `done`, `error` and `word_count`, and loads the write pointer with `BASE`.
  - LEN_HI -> LEN_LO on byte accept.
  - LEN_LO on byte accept -> ERR if N == 0 or N > 4096, else -> DATA.
  - DATA -> WRITE on the 4th byte accept of a word.
  - WRITE -> DONE if this was word N, else -> DATA. The write pointer and `word_count` increment as WRITE is left.
- `start` in LEN_HI, LEN_LO, DATA or WRITE is ignored.
- `in_ready` = 1 only in LEN_HI, LEN_LO and DATA; it is 0 in WRITE, IDLE, DONE and ERR.
- `busy` = 1 in LEN_HI, LEN_LO, DATA and WRITE.
- `cpu_hold` = 1 in every state except DONE. A CPU is released only by a successful load.
- `error` = 1 in ERR. It is sticky until `start` or reset.
- `done` = 1 in DONE.
- Address arithmetic: `im_addr` = (`BASE` + word index) mod 2^12. If `BASE` + N exceeds 4096, addresses wrap silently to word 0.
- `im_wdata` and `im_addr` are registered. They are valid whenever `im_we` = 1 and hold their last value otherwise.
- Reset mid-load: the state machine returns to IDLE immediately and no further `im_we` is issued. Words already written stay in the store, and the partially assembled word is discarded.

## Timing
- Reset values: `in_ready` 0, `im_we` 0, `im_addr` 0, `im_wdata` 0, `busy` 0, `done` 0, `error` 0, `cpu_hold` 1, `word_count` 0.
- `start` sampled at edge k -> LEN_HI from cycle k+1, with `in_ready` = 1 and `busy` = 1 in cycle k+1.
- 4th byte of a word accepted at edge k -> `im_we` = 1 during cycle k+1 only. `word_count` shows the new value from cycle k+2.
- Peak throughput is 1 word per 5 cycles (4 accepts plus 1 WRITE). An `in_valid` stalled in WRITE is held by the source.
- Last word: WRITE at cycle k+1 -> `done` = 1 and `cpu_hold` = 0 from cycle k+2.
- Bad length byte accepted at edge k -> `error` = 1 from cycle k+1. No `im_we` is issued for that load.

## Test plan
- Reset, then `start`; stream 00 02 | 24 08 00 05 | 00 00 00 0C, with `in_valid` held high -> exactly two `im_we` pulses:
  - addr 0x000, data 0x24080005;
  - addr 0x001, data 0x0000000C.
  - Then `done` = 1, `cpu_hold` = 0, `word_count` = 2, `in_ready` = 0.
- Same stream with `in_valid` toggled every other cycle -> identical writes. No byte is lost or duplicated, and no acceptance occurs in WRITE.
- Length 00 00, then separately 10 01 (N = 4097) -> `error` = 1, `cpu_hold` = 1, no `im_we`. A following `start` with a valid stream clears `error` and loads correctly.
- `BASE` = 4095, N = 2 -> writes land at addr 0xFFF then 0x000.
- `reset_n` low after 5 data bytes -> outputs return to reset values at once, with no `im_we` while low or after release. `start` plus a full stream then works normally.
- `start` pulsed during DATA -> ignored; the load completes with its original N.
